div_share_scheduler: RTL and testbench

Round-robin scheduler that shares one 16-bit restoring divider datapath and its controller among up to four requesters. It accepts a dividend/divisor pair from each requester and sequences the divider with a start pulse on the divider's clear input. It then waits for the divider's Done, filtering out the stale Done left over from the previous run, and returns quotient, remainder and requester ID. Divide-by-zero is short-circuited without touching the divider.

---
 rtl/div_share_scheduler.sv | 163 ++++++++++++++++
 tb/tb_div_share_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_scheduler.sv
// Round-robin scheduler sharing one restoring divider among N_REQ requesters.
// Optional BUSY watchdog is compiled in when DIV_TIMEOUT_EN is defined.
module div_share_scheduler #(
   parameter int N_REQ      = 4,
   parameter int WIDTH      = 16,
   parameter int DONE_BLANK = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                   clk,
   input  logic                   clear_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] dividend_in,
   input  logic [N_REQ*WIDTH-1:0] divisor_in,
   output logic [N_REQ-1:0]       ack,
   output logic                   rsp_valid,
   output logic [1:0]             rsp_id,
   output logic [WIDTH-1:0]       rsp_quot,
   output logic [WIDTH-1:0]       rsp_rem,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   div_start,
   output logic [WIDTH-1:0]       div_a,
   output logic [WIDTH-1:0]       div_b,
   input  logic                   div_done,
   input  logic [WIDTH-1:0]       div_q,
   input  logic [WIDTH-1:0]       div_r
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

   localparam logic [7:0] BLANK = 8'(DONE_BLANK);
   localparam logic [1:0] LAST  = 2'(N_REQ - 1);
`ifdef DIV_TIMEOUT_EN
   localparam logic [7:0] TMO   = 8'(TIMEOUT);
`endif

   if (N_REQ < 2 || N_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_cfg
      $error("div_share_scheduler: illegal N_REQ or TIMEOUT");
   end

   state_t             state, state_n;
   logic [1:0]         rr_ptr, rr_n, id_n, win;
   logic [7:0]         cnt, cnt_n;
   logic [WIDTH-1:0]   a_n, b_n, quot_n, rem_n, win_a, win_b;
   logic               err_n, found;
   logic [N_REQ-1:0]   ack_n;

   always_comb begin
      state_n = state;
      id_n    = rsp_id;
      a_n     = div_a;
      b_n     = div_b;
      quot_n  = rsp_quot;
      rem_n   = rsp_rem;
      err_n   = rsp_err;
      cnt_n   = cnt;
      rr_n    = rr_ptr;
      found   = 1'b0;
      win     = '0;
      win_a   = '0;
      win_b   = '0;
      ack_n   = '0;

      // two passes give the circular search starting at rr_ptr
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && 2'(i) >= rr_ptr) begin
            found = 1'b1;
            win   = 2'(i);
            win_a = dividend_in[i*WIDTH +: WIDTH];
            win_b = divisor_in[i*WIDTH +: WIDTH];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && 2'(i) < rr_ptr) begin
            found = 1'b1;
            win   = 2'(i);
            win_a = dividend_in[i*WIDTH +: WIDTH];
            win_b = divisor_in[i*WIDTH +: WIDTH];
         end
      end

      unique case (state)
         IDLE: begin
            if (found) begin
               id_n = win;
               a_n  = win_a;
               b_n  = win_b;
               if (win_b == '0) begin
                  state_n = RESP;
                  quot_n  = '1;
                  rem_n   = win_a;
                  err_n   = 1'b1;
               end else begin
                  state_n = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_n   = '0;
            state_n = BUSY;
         end
         BUSY: begin
            if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
            // the divider still shows the previous Done until it clears
            if (cnt >= BLANK && div_done) begin
               state_n = RESP;
               quot_n  = div_q;
               rem_n   = div_r;
               err_n   = 1'b0;
            end
`ifdef DIV_TIMEOUT_EN
            else if (cnt == TMO) begin
               state_n = RESP;
               quot_n  = '0;
               rem_n   = '0;
               err_n   = 1'b1;
            end
`endif
         end
         RESP: begin
            rr_n    = (rsp_id == LAST) ? 2'd0 : rsp_id + 2'd1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      for (int i = 0; i < N_REQ; i++)
         ack_n[i] = (state_n == RESP) && (id_n == 2'(i));
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cnt       <= '0;
         rsp_id    <= '0;
         rsp_quot  <= '0;
         rsp_rem   <= '0;
         rsp_err   <= 1'b0;
         rsp_valid <= 1'b0;
         ack       <= '0;
         busy      <= 1'b0;
         div_start <= 1'b0;
         div_a     <= '0;
         div_b     <= '0;
      end else begin
         state     <= state_n;
         rr_ptr    <= rr_n;
         cnt       <= cnt_n;
         rsp_id    <= id_n;
         rsp_quot  <= quot_n;
         rsp_rem   <= rem_n;
         rsp_err   <= err_n;
         rsp_valid <= (state_n == RESP);
         ack       <= ack_n;
         busy      <= (state_n == ISSUE) || (state_n == BUSY);
         div_start <= (state_n == ISSUE);
         div_a     <= a_n;
         div_b     <= b_n;
      end
   end

endmodule

// File: tb/tb_div_share_scheduler.sv
// Directed bench for div_share_scheduler; divider responses are scripted.
// The timeout scenario runs only when DIV_TIMEOUT_EN is defined.
module tb_div_share_scheduler;

   logic        clk = 1'b0;
   logic        clear_n;
   logic [3:0]  req;
   logic [63:0] dividend_in, divisor_in;
   logic [3:0]  ack;
   logic        rsp_valid, rsp_err, busy, div_start;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_quot, rsp_rem, div_a, div_b;
   logic        div_done;
   logic [15:0] div_q, div_r;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   div_share_scheduler #(
      .N_REQ(4), .WIDTH(16), .DONE_BLANK(2), .TIMEOUT(20)
   ) dut (
      .clk(clk), .clear_n(clear_n), .req(req),
      .dividend_in(dividend_in), .divisor_in(divisor_in),
      .ack(ack), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_quot(rsp_quot), .rsp_rem(rsp_rem), .rsp_err(rsp_err),
      .busy(busy), .div_start(div_start),
      .div_a(div_a), .div_b(div_b),
      .div_done(div_done), .div_q(div_q), .div_r(div_r)
   );

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_start(output bit seen, output int n);
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         n++;
         if (div_start === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      clear_n = 1'b0;
      req = '0; dividend_in = '0; divisor_in = '0;
      div_done = 1'b0; div_q = '0; div_r = '0;
      step(); step();
      vectors++;
      if ({ack, rsp_valid, rsp_err, busy, div_start} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 00000000",
                  {ack, rsp_valid, rsp_err, busy, div_start});
      end
      vectors++;
      if ({rsp_id, rsp_quot, rsp_rem, div_a, div_b} !== 66'd0) begin
         miscompares++;
         $display("FAIL reset_data got %h want 0",
                  {rsp_id, rsp_quot, rsp_rem, div_a, div_b});
      end
      clear_n = 1'b1;
      step(); step();
      vectors++;
      if (busy !== 1'b0 || div_start !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_no_req busy=%b start=%b want 0 0", busy, div_start);
      end
   endtask

   // stale Done held high through ISSUE and the first two BUSY cycles
   task automatic test_single_stale();
      req = 4'b0010;
      dividend_in[16 +: 16] = 16'd1000;
      divisor_in[16 +: 16]  = 16'd7;
      div_done = 1'b1; div_q = 16'hDEAD; div_r = 16'hBEEF;
      step();
      vectors++;
      if (div_start !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_issue start=%b busy=%b want 1 1", div_start, busy);
      end
      vectors++;
      if (div_a !== 16'd1000 || div_b !== 16'd7) begin
         miscompares++;
         $display("FAIL single_ops a=%0d b=%0d want 1000 7", div_a, div_b);
      end
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (rsp_valid !== 1'b0 || div_start !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_blank[%0d] valid=%b start=%b want 0 0",
                     i, rsp_valid, div_start);
         end
      end
      div_done = 1'b0;
      step(); step(); step();
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL single_wait valid=%b busy=%b want 0 1", rsp_valid, busy);
      end
      div_done = 1'b1; div_q = 16'd142; div_r = 16'd6;
      step();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
         miscompares++;
         $display("FAIL single_rsp valid=%b id=%0d err=%b want 1 1 0",
                  rsp_valid, rsp_id, rsp_err);
      end
      vectors++;
      if (rsp_quot !== 16'd142 || rsp_rem !== 16'd6) begin
         miscompares++;
         $display("FAIL single_qr q=%0d r=%0d want 142 6", rsp_quot, rsp_rem);
      end
      vectors++;
      if (ack !== 4'b0010 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL single_ack ack=%b busy=%b want 0010 0", ack, busy);
      end
      div_done = 1'b0;
      step();
      vectors++;
      if (rsp_valid !== 1'b0 || ack !== 4'b0000) begin
         miscompares++;
         $display("FAIL single_pulse valid=%b ack=%b want 0 0000", rsp_valid, ack);
      end
   endtask

   task automatic test_div_zero();
      req = 4'b0100;
      dividend_in[32 +: 16] = 16'h1234;
      divisor_in[32 +: 16]  = 16'h0000;
      step();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_err !== 1'b1) begin
         miscompares++;
         $display("FAIL dz_rsp valid=%b id=%0d err=%b want 1 2 1",
                  rsp_valid, rsp_id, rsp_err);
      end
      vectors++;
      if (rsp_quot !== 16'hFFFF || rsp_rem !== 16'h1234) begin
         miscompares++;
         $display("FAIL dz_qr q=%h r=%h want ffff 1234", rsp_quot, rsp_rem);
      end
      vectors++;
      if (ack !== 4'b0100 || div_start !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL dz_ctrl ack=%b start=%b busy=%b want 0100 0 0",
                  ack, div_start, busy);
      end
      req = 4'b0000;
      step();
      vectors++;
      if (rsp_valid !== 1'b0 || div_start !== 1'b0) begin
         miscompares++;
         $display("FAIL dz_after valid=%b start=%b want 0 0", rsp_valid, div_start);
      end
   endtask

   task automatic test_reset_busy();
      bit seen;
      int n;
      req = 4'b0001;
      dividend_in[0 +: 16] = 16'd50;
      divisor_in[0 +: 16]  = 16'd10;
      div_done = 1'b0;
      step(); step(); step();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rb_busy got %b want 1", busy);
      end
      clear_n = 1'b0;
      #1;
      vectors++;
      if ({busy, div_start, rsp_valid, ack} !== 7'd0 || div_a !== 16'd0) begin
         miscompares++;
         $display("FAIL rb_async ctrl=%b a=%0d want 0000000 0",
                  {busy, div_start, rsp_valid, ack}, div_a);
      end
      step();
      clear_n = 1'b1;
      wait_start(seen, n);
      vectors++;
      if (!seen || n !== 1) begin
         miscompares++;
         $display("FAIL rb_reissue seen=%b cycles=%0d want 1 1", seen, n);
      end
      req = 4'b0000;
      step(); step(); step();
      div_done = 1'b1; div_q = 16'd5; div_r = 16'd0;
      step();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_quot !== 16'd5) begin
         miscompares++;
         $display("FAIL rb_rsp valid=%b id=%0d q=%0d want 1 0 5",
                  rsp_valid, rsp_id, rsp_quot);
      end
      div_done = 1'b0;
      step();
   endtask

   task automatic test_round_robin();
      bit seen;
      int n;
      clear_n = 1'b0;
      step();
      clear_n = 1'b1;
      divisor_in = {4{16'd3}};
      dividend_in = {16'd40, 16'd30, 16'd20, 16'd10};
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_start(seen, n);
         vectors++;
         if (!seen || (i > 0 && n !== 2)) begin
            miscompares++;
            $display("FAIL rr_grant[%0d] seen=%b cycles=%0d want 1 2", i, seen, n);
         end
         step(); step(); step();
         div_done = 1'b1; div_q = 16'h1000 + 16'(i); div_r = 16'(i);
         step();
         vectors++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(i % 4)
             || ack !== (4'b0001 << (i % 4))) begin
            miscompares++;
            $display("FAIL rr_order[%0d] valid=%b id=%0d ack=%b want 1 %0d %b",
                     i, rsp_valid, rsp_id, ack, i % 4, 4'b0001 << (i % 4));
         end
         vectors++;
         if (rsp_quot !== 16'h1000 + 16'(i) || rsp_rem !== 16'(i)) begin
            miscompares++;
            $display("FAIL rr_qr[%0d] q=%h r=%h want %h %h",
                     i, rsp_quot, rsp_rem, 16'h1000 + 16'(i), 16'(i));
         end
         div_done = 1'b0;
      end
      req = 4'b0000;
      step(); step();
   endtask

`ifdef DIV_TIMEOUT_EN
   task automatic test_timeout();
      bit seen;
      int n;
      int k;
      req = 4'b0001;
      dividend_in[0 +: 16] = 16'd9;
      divisor_in[0 +: 16]  = 16'd2;
      div_done = 1'b0;
      wait_start(seen, n);
      req = 4'b0000;
      k = 0;
      for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) begin
         step();
         k++;
      end
      vectors++;
      if (!seen || k !== 22) begin
         miscompares++;
         $display("FAIL tmo_latency seen=%b cycles=%0d want 1 22", seen, k);
      end
      vectors++;
      if (rsp_err !== 1'b1 || rsp_quot !== 16'd0 || rsp_rem !== 16'd0) begin
         miscompares++;
         $display("FAIL tmo_rsp err=%b q=%0d r=%0d want 1 0 0",
                  rsp_err, rsp_quot, rsp_rem);
      end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single_stale();
      test_div_zero();
      test_reset_busy();
      test_round_robin();
`ifdef DIV_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
